// File: rtl/two_to_four_demux_collector.sv
`default_nettype none
// ============================================================================
//  Module   : two_to_four_demux_collector
//  Purpose  : Receive-side partner of four_to_two_mux. Accepts pairs of
//             WIDTH-bit lanes (M, N) tagged with a slot-pair select SE,
//             scatters them into four slot registers A..D, and presents
//             the assembled frame on a valid/ready handshake once all four
//             slots have been written.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1      rising-edge clock
//    rst          in   1      synchronous active-high reset
//    M, N         in   WIDTH  first / second lane of the incoming pair
//    SE           in   2      slot-pair select (00:A,B 01:C,D 10:B,C 11:D,A)
//    in_valid     in   1      incoming pair valid
//    in_ready     out  1      block can accept a pair (COLLECT state)
//    A, B, C, D   out  WIDTH  slot 0..3 registers
//    out_valid    out  1      A..D hold a complete frame (HOLD state)
//    out_ready    in   1      downstream accepts the frame
//    overlap_err  out  1      one-cycle pulse: accepted pair rewrote a
//                             slot that was already filled
//    frame_cnt    out  CNT_W  delivered-frame count, wraps modulo 2^CNT_W
// ============================================================================
module two_to_four_demux_collector #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] M,
  input  logic [WIDTH-1:0] N,
  input  logic [1:0]       SE,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overlap_err,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] slot [4];
  logic [3:0]       fill_mask;

  logic [1:0]       first_slot;
  logic [1:0]       second_slot;
  logic [3:0]       hit_mask;
  logic [3:0]       next_mask;
  logic             accept;
  logic             overlap;

  // in_ready depends on state only, so upstream never sees a
  // combinational path from its own in_valid.
  assign in_ready = (state == COLLECT);
  assign accept   = in_valid && in_ready;

  // Slot-pair decode; M always lands in first_slot, N in second_slot.
  always_comb begin
    first_slot  = 2'd0;
    second_slot = 2'd1;
    case (SE)
      2'b00: begin first_slot = 2'd0; second_slot = 2'd1; end
      2'b01: begin first_slot = 2'd2; second_slot = 2'd3; end
      2'b10: begin first_slot = 2'd1; second_slot = 2'd2; end
      2'b11: begin first_slot = 2'd3; second_slot = 2'd0; end
      default: begin first_slot = 2'd0; second_slot = 2'd1; end
    endcase
  end

  always_comb begin
    hit_mask  = (4'b0001 << first_slot) | (4'b0001 << second_slot);
    next_mask = fill_mask | hit_mask;
    overlap   = |(fill_mask & hit_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      fill_mask   <= 4'b0000;
      out_valid   <= 1'b0;
      overlap_err <= 1'b0;
      frame_cnt   <= '0;
      for (int i = 0; i < 4; i++) begin
        slot[i] <= '0;
      end
    end else begin
      // overlap_err is a single-cycle pulse unless re-armed below.
      overlap_err <= 1'b0;
      case (state)
        COLLECT: begin
          if (accept) begin
            slot[first_slot]  <= M;
            slot[second_slot] <= N;
            fill_mask         <= next_mask;
            overlap_err       <= overlap;
            if (next_mask == 4'b1111) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          // out_valid is 1 throughout HOLD, so out_ready alone completes
          // the handshake. Slot contents are left in place; only the mask
          // is cleared so the next frame starts empty.
          if (out_ready) begin
            state     <= COLLECT;
            out_valid <= 1'b0;
            fill_mask <= 4'b0000;
            frame_cnt <= frame_cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= COLLECT;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign A = slot[0];
  assign B = slot[1];
  assign C = slot[2];
  assign D = slot[3];

endmodule
`default_nettype wire
